seven_segment_scanner: RTL
==========================

// Module: seven_segment_scanner
// PURPOSE
//   Drives an N-digit common-anode 7-segment display by time-multiplexing one digit per scan slot.
//   - Latches a packed hex value through a load strobe.
//   - Decodes each nibble to active-low segments.
//   - Cycles the digit anodes at a programmable refresh rate.
//   - Sits between the UART receive/data path and the board display pins.
// PARAMETERS
//   NUM_DIGITS  4           digits driven (1..8)
//   CLK_HZ      100000000   clk frequency
//   REFRESH_HZ  1000        full-frame refresh rate
//   GUARD       16          anti-ghost cycles per slot with all anodes off (must be < SLOT)
// PORTS
//   clk         in   1              system clock
//   rst         in   1              synchronous, active-high reset
//   load        in   1              1-cycle strobe: capture value/dp_in/digit_en
//   value       in   4*NUM_DIGITS   hex nibbles; digit 0 = value[3:0]
//   dp_in       in   NUM_DIGITS     decimal point request per digit (1 = lit)
//   digit_en    in   NUM_DIGITS     1 = digit shown, 0 = forced blank
//   an          out  NUM_DIGITS     anodes, active-low, one-hot-low when driven
//   seg         out  [0:6]          segments a..g, bit 0 = a, active-low
//   dp          out  1              decimal point, active-low
//   frame_tick  out  1              1-cycle pulse when slot 0 begins
// BEHAVIOUR
//   - Reset: an = all 1, seg = 7'b1111111, dp = 1, frame_tick = 0.
//     Slot counter, digit index, shadow and display registers = 0; pending = 0.
//   - SLOT = CLK_HZ/(REFRESH_HZ*NUM_DIGITS); slot counter counts 0..SLOT-1, then wraps.
//     At wrap, index advances; NUM_DIGITS-1 wraps to 0.
//   - Guard: while slot counter < GUARD, an = all 1.
//     Otherwise an[index] = 0 and all other an bits = 1.
//   - Outputs are registered: an/seg/dp reflect the index and count of the previous cycle (1-cycle latency).
//   - Load: on load, capture into shadow and set pending.
//     Shadow moves to display only when index wraps to 0 (tear-free frame), then pending clears.
//     load in the same cycle as the transfer: the new data goes to display directly; pending stays 0.
//     Repeated loads before transfer: the last one wins.
//   - Decode: 0-F standard hex glyphs, active-low, a..g order.
//     0 = 0000001, 1 = 1001111, 8 = 0000000, 9 = 0000100, A = 0001000, F = 0111000.
//     digit_en = 0 gives seg = 1111111 and dp = 1.
//   - frame_tick = 1 in the cycle the outputs first present slot 0, including its guard phase.
//   - Reset mid-scan: all state returns to reset values the next edge; no partial-frame output.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN
//     Defined: digits above the most-significant nonzero enabled nibble show blank when their nibble is 0.
//       Digit 0 is never blanked, so value 0 shows a single "0".
//       A digit with a dp request is still lit for its dp.
//     Undefined: all enabled digits are shown, zeros included.
// STRUCTURE
//   - Package seg_pkg: SEG_BLANK = 7'b1111111; 16-entry localparam glyph table;
//     typedef logic [0:6] seg_t.
//   - Sub-module hex_to_seg (combinational nibble + blank -> seg_t), instantiated once on the selected digit.
//   - Top holds the counters, shadow/display registers and output registers.
// TESTING (NUM_DIGITS=4, CLK_HZ=1000, REFRESH_HZ=50 -> SLOT=5, GUARD=1)
//   1. Reset for 3 cycles, release.
//      -> an=1111, seg=1111111, dp=1 until the first slot.
//      -> Then an = 1110,1101,1011,0111 repeating, 4 active cycles of each per slot.
//      -> frame_tick every 20 cycles.
//   2. load value=16'h12AF, digit_en=4'hF mid-frame.
//      -> Display unchanged until the next frame_tick.
//      -> Then digits 0..3 show F=0111000, A=0001000, 2=0010010, 1=1001111.
//   3. Two loads in one frame (16'h1111, then 16'h2222).
//      -> Next frame shows 2222 only; 1111 never appears.
//   4. digit_en=4'b0101, dp_in=4'b0001.
//      -> Digits 1 and 3 show seg=1111111, dp=1; digit 0 shows dp=0.
//   5. Assert rst while an=1011 mid-slot.
//      -> Next cycle an=1111, seg=1111111; scan restarts at digit 0.
//   6. LEADING_ZERO_BLANK_EN defined, value=16'h0030.
//      -> Digits 3 and 2 are blank, digit 1 shows 3, digit 0 shows 0.
//      -> With value=0 only digit 0 is lit.

Source files
------------

// File: rtl/seven_segment_scanner_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment scanner.
// Segment vectors are indexed a..g as bits 0..6 and are active-low.
package seg_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Hex glyphs 0..F, written in a..g order.
    localparam seg_t GLYPHS [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Display-side bundle of the scanner: load strobe with frame data in,
// multiplexed anode/segment drive out.
interface seven_segment_scanner_if
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
);

    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   an;
    seg_t                    seg;
    logic                    dp;
    logic                    frame_tick;

    modport master (
        output load, value, dp_in, digit_en,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  load, value, dp_in, digit_en,
        output an, seg, dp, frame_tick
    );

endinterface

// File: rtl/seven_segment_scanner_hex_to_seg.sv
// Combinational nibble-to-segment decoder with a forced-blank input.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            seg_o = GLYPHS[nibble_i];
        end
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// N-digit common-anode scanner with tear-free shadow/display double buffering.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero one.
module seven_segment_scanner
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned REFRESH_HZ = 1000,
    parameter int unsigned GUARD      = 16
) (
    input logic                    clk,
    input logic                    rst,
    seven_segment_scanner_if.slave bus
);

    localparam int unsigned SLOT  = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int unsigned CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] val_sh_q, val_sh_d, val_disp_q, val_disp_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d, dp_disp_q, dp_disp_d;
    logic [NUM_DIGITS-1:0]   en_sh_q, en_sh_d, en_disp_q, en_disp_d;
    logic                    pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    seg_t                    seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    ft_q, ft_d;

    logic       wrap_slot;
    logic       wrap_frame;
    logic [3:0] nib;
    logic       digit_on;
    logic       lz_blank;
    seg_t       seg_sel;

    assign wrap_slot  = (cnt_q == CNT_LAST);
    assign wrap_frame = wrap_slot && (idx_q == IDX_LAST);
    assign nib        = val_disp_q[32'(idx_q)*4 +: 4];
    assign digit_on   = en_disp_q[idx_q];

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        lz_blank = 1'b0;
        if (idx_q != '0 && nib == 4'h0) begin
            lz_blank = 1'b1;
            for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
                if (j > 32'(idx_q) && en_disp_q[j] && val_disp_q[j*4 +: 4] != 4'h0) begin
                    lz_blank = 1'b0;
                end
            end
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    hex_to_seg u_dec (
        .nibble_i (nib),
        .blank_i  (!digit_on || lz_blank),
        .seg_o    (seg_sel)
    );

    always_comb begin
        cnt_d      = wrap_slot ? '0 : cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        val_sh_d   = val_sh_q;
        dp_sh_d    = dp_sh_q;
        en_sh_d    = en_sh_q;
        val_disp_d = val_disp_q;
        dp_disp_d  = dp_disp_q;
        en_disp_d  = en_disp_q;
        pend_d     = pend_q;

        if (wrap_slot) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        if (bus.load) begin
            val_sh_d = bus.value;
            dp_sh_d  = bus.dp_in;
            en_sh_d  = bus.digit_en;
            pend_d   = 1'b1;
        end

        // A load coinciding with the frame boundary bypasses the shadow.
        if (wrap_frame) begin
            if (bus.load) begin
                val_disp_d = bus.value;
                dp_disp_d  = bus.dp_in;
                en_disp_d  = bus.digit_en;
                pend_d     = 1'b0;
            end else if (pend_q) begin
                val_disp_d = val_sh_q;
                dp_disp_d  = dp_sh_q;
                en_disp_d  = en_sh_q;
                pend_d     = 1'b0;
            end
        end

        an_d = '1;
        if (cnt_q >= GUARD_C) begin
            an_d[idx_q] = 1'b0;
        end
        seg_d = seg_sel;
        dp_d  = !(digit_on && dp_disp_q[idx_q]);
        ft_d  = (cnt_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            val_sh_q   <= '0;
            dp_sh_q    <= '0;
            en_sh_q    <= '0;
            val_disp_q <= '0;
            dp_disp_q  <= '0;
            en_disp_q  <= '0;
            pend_q     <= 1'b0;
            an_q       <= '1;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            ft_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            val_sh_q   <= val_sh_d;
            dp_sh_q    <= dp_sh_d;
            en_sh_q    <= en_sh_d;
            val_disp_q <= val_disp_d;
            dp_disp_q  <= dp_disp_d;
            en_disp_q  <= en_disp_d;
            pend_q     <= pend_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            ft_q       <= ft_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = ft_q;

endmodule
